// File: rtl/cdc_rx_fifo.sv
// -----------------------------------------------------------------------------
// cdc_rx_fifo
//
// Small first-word-fall-through FIFO on the destination side of a pulse/bus
// synchroniser. Each single-cycle in_pulse carries one in_data word. The FIFO
// stores it, and the consumer drains it with a valid/ready handshake. A pulse
// that finds the FIFO full, with no pop in the same cycle, is dropped. Drops
// are recorded in a saturating counter and in a sticky flag. Both can be
// cleared by software.
//
// Ports
//   dst_clk          destination-domain clock (only clock)
//   reset_i          synchronous active-high reset
//   in_pulse         single-cycle strobe qualifying in_data
//   in_data          payload
//   out_valid        head entry available (== !empty)
//   out_ready        consumer accepts head entry
//   out_data         head entry
//   level            number of stored entries (registered)
//   full / empty     registered occupancy flags
//   overflow_count   saturating count of dropped pulses
//   overflow_sticky  set on any drop, held until clear_overflow
//   clear_overflow   synchronous clear of the overflow state
// -----------------------------------------------------------------------------
module cdc_rx_fifo #(
   parameter int unsigned pDATA_WIDTH = 8,
   parameter int unsigned pDEPTH      = 4,
   parameter int unsigned pCNT_WIDTH  = 8
) (
   input  logic                       dst_clk,
   input  logic                       reset_i,
   input  logic                       in_pulse,
   input  logic [pDATA_WIDTH-1:0]     in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [pDATA_WIDTH-1:0]     out_data,
   output logic [$clog2(pDEPTH):0]    level,
   output logic                       full,
   output logic                       empty,
   output logic [pCNT_WIDTH-1:0]      overflow_count,
   output logic                       overflow_sticky,
   input  logic                       clear_overflow
);

   localparam int unsigned ADDR_W = $clog2(pDEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]       level_q,  level_d;
   logic                   full_q,   full_d;
   logic                   empty_q,  empty_d;
   logic [pCNT_WIDTH-1:0]  cnt_q,    cnt_d;
   logic                   sticky_q, sticky_d;

   logic                   push, pop, drop;

   // Pop depends only on registered state and out_ready. A pop frees one slot,
   // so a pulse that arrives while the FIFO is full is still accepted when a
   // pop happens in the same cycle.
   always_comb begin
      pop  = !empty_q && out_ready;
      push = in_pulse && (!full_q || pop);
      drop = in_pulse && full_q && !pop;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Pointers carry one extra wrap bit. When the addresses match, equal
      // wrap bits mean the FIFO is empty and different wrap bits mean it is
      // full.
      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
      level_d = wr_ptr_d - rd_ptr_d;
   end

   // A drop in the same cycle as a clear is kept as a count of 1, so the
   // event is not lost.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (clear_overflow) begin
         cnt_d    = drop ? pCNT_WIDTH'(1) : '0;
         sticky_d = drop;
      end else if (drop) begin
         sticky_d = 1'b1;
         if (!(&cnt_q)) cnt_d = cnt_q + pCNT_WIDTH'(1);
      end
   end

   always_ff @(posedge dst_clk) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   // Storage is cleared on reset so that out_data reads as zero afterwards.
   always_ff @(posedge dst_clk) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < pDEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
      end
   end

   always_comb begin
      out_valid       = !empty_q;
      out_data        = mem_q[rd_ptr_q[ADDR_W-1:0]];
      level           = level_q;
      full            = full_q;
      empty           = empty_q;
      overflow_count  = cnt_q;
      overflow_sticky = sticky_q;
   end

endmodule

// File: tb/tb_cdc_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_cdc_rx_fifo
//
// Directed bench for cdc_rx_fifo. It drives a default instance and a second
// instance with a 2-bit overflow counter from the same stimulus. The second
// instance exposes counter saturation.
// -----------------------------------------------------------------------------
module tb_cdc_rx_fifo;

   logic       dst_clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       in_pulse = 1'b0;
   logic [7:0] in_data = '0;
   logic       out_ready = 1'b0;
   logic       clear_overflow = 1'b0;

   logic       out_valid,  out_valid2;
   logic [7:0] out_data,   out_data2;
   logic [2:0] level,      level2;
   logic       full,       full2;
   logic       empty,      empty2;
   logic [7:0] ovf_cnt;
   logic [1:0] ovf_cnt2;
   logic       sticky,     sticky2;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 dst_clk = ~dst_clk;

   cdc_rx_fifo #(.pDATA_WIDTH(8), .pDEPTH(4), .pCNT_WIDTH(8)) dut (
      .dst_clk(dst_clk), .reset_i(reset_i), .in_pulse(in_pulse),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .level(level), .full(full), .empty(empty),
      .overflow_count(ovf_cnt), .overflow_sticky(sticky),
      .clear_overflow(clear_overflow)
   );

   cdc_rx_fifo #(.pDATA_WIDTH(8), .pDEPTH(4), .pCNT_WIDTH(2)) dut2 (
      .dst_clk(dst_clk), .reset_i(reset_i), .in_pulse(in_pulse),
      .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .level(level2), .full(full2), .empty(empty2),
      .overflow_count(ovf_cnt2), .overflow_sticky(sticky2),
      .clear_overflow(clear_overflow)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge. Outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge dst_clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] d);
      in_pulse = 1'b1;
      in_data  = d;
      step();
      in_pulse = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_level",  32'(level), 32'd0);
      check("rst_empty",  32'(empty), 32'd1);
      check("rst_full",   32'(full), 32'd0);
      check("rst_valid",  32'(out_valid), 32'd0);
      check("rst_cnt",    32'(ovf_cnt), 32'd0);
      check("rst_sticky", 32'(sticky), 32'd0);
      check("rst_data",   32'(out_data), 32'd0);
      reset_i = 1'b0;

      // Single push then drain. The push is accepted on the first edge after
      // reset is released.
      out_ready = 1'b1;
      pulse(8'hA5);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_data",  32'(out_data), 32'hA5);
      check("single_level", 32'(level), 32'd1);
      step();
      check("single_valid_gone", 32'(out_valid), 32'd0);
      check("single_empty", 32'(empty), 32'd1);

      // out_ready while empty is ignored
      step();
      step();
      check("idle_ready_level", 32'(level), 32'd0);
      check("idle_ready_empty", 32'(empty), 32'd1);

      // Fill 01..04
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) pulse(8'(i));
      check("fill_full",  32'(full), 32'd1);
      check("fill_level", 32'(level), 32'd4);
      check("fill_head",  32'(out_data), 32'h01);
      step();
      check("fill_stable", 32'(out_data), 32'h01);

      // Three drops
      for (int i = 0; i < 3; i++) pulse(8'hE0 + 8'(i));
      check("ovf_cnt3",   32'(ovf_cnt), 32'd3);
      check("ovf_sticky", 32'(sticky), 32'd1);
      check("ovf_level",  32'(level), 32'd4);
      check("ovf_head",   32'(out_data), 32'h01);

      // Two more drops: 5 total, the 2-bit counter saturates at 3
      pulse(8'hE3);
      pulse(8'hE4);
      check("ovf_cnt5",   32'(ovf_cnt), 32'd5);
      check("sat_cnt2",   32'(ovf_cnt2), 32'd3);

      // Clear without a drop
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      check("clr_cnt",    32'(ovf_cnt), 32'd0);
      check("clr_sticky", 32'(sticky), 32'd0);
      check("clr_cnt2",   32'(ovf_cnt2), 32'd0);

      // Drop in the same cycle as a clear
      clear_overflow = 1'b1;
      pulse(8'hE5);
      clear_overflow = 1'b0;
      check("coll_cnt",    32'(ovf_cnt), 32'd1);
      check("coll_sticky", 32'(sticky), 32'd1);
      check("coll_cnt2",   32'(ovf_cnt2), 32'd1);
      check("coll_head",   32'(out_data), 32'h01);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;

      // Push and pop at full: no drop, level stays 4, 0x55 behind 02..04
      out_ready = 1'b1;
      pulse(8'h55);
      check("pp_level", 32'(level), 32'd4);
      check("pp_cnt",   32'(ovf_cnt), 32'd0);
      check("pp_full",  32'(full), 32'd1);
      check("pp_head0", 32'(out_data), 32'h02);
      step();
      check("pp_head1", 32'(out_data), 32'h03);
      step();
      check("pp_head2", 32'(out_data), 32'h04);
      step();
      check("pp_head3", 32'(out_data), 32'h55);
      step();
      check("pp_empty", 32'(empty), 32'd1);
      check("pp_valid", 32'(out_valid), 32'd0);

      // Reset mid-stream with level 3, a pending drop count and a pulse
      // during reset
      out_ready = 1'b0;
      pulse(8'h11);
      pulse(8'h22);
      pulse(8'h33);
      pulse(8'h44);
      pulse(8'h99);
      check("pre_rst_cnt", 32'(ovf_cnt), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("pre_rst_level", 32'(level), 32'd3);
      check("pre_rst_head",  32'(out_data), 32'h22);
      reset_i = 1'b1;
      pulse(8'h66);
      reset_i = 1'b0;
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_cnt",   32'(ovf_cnt), 32'd0);
      check("mid_rst_sticky", 32'(sticky), 32'd0);
      check("mid_rst_data",  32'(out_data), 32'd0);
      pulse(8'h77);
      check("post_rst_level", 32'(level), 32'd1);
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_data",  32'(out_data), 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
